// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter with a small byte FIFO in front of the shift register.
//   Frame on the line: start(0), data[7]..data[0] MSB first, optional even
//   parity (^data), stop(1). Every bit lasts CLKS_PER_BIT cycles of clk_3125.
//   When a stop bit ends and another byte is queued, the next start bit follows
//   immediately, so queued characters leave back-to-back with no idle gap.
//
// Ports
//   clk_3125       in   system clock, all state changes on posedge
//   rst            in   asynchronous, active-high reset
//   tx_data  [7:0] in   byte to queue
//   tx_valid       in   tx_data is valid this cycle
//   tx_ready       out  FIFO can accept a byte (not full)
//   tx             out  serial line, idles high, registered
//   tx_busy        out  a frame is on the line
//   tx_done        out  1-cycle pulse on the final cycle of each stop bit
//   tx_fifo_level  out  bytes currently queued
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 14,  // >= 2
  parameter int FIFO_DEPTH   = 4,   // power of 2, >= 2
  parameter int PARITY_EN    = 1
) (
  input  logic                              clk_3125,
  input  logic                              rst,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CYC_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  // Transmit state
  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_tx_done;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_bit_end;

  assign w_empty   = (r_count == '0);
  assign w_bit_end = (r_cyc == CYC_W'(CLKS_PER_BIT - 1));
  assign w_push    = tx_valid && tx_ready;
  // The shifter takes the FIFO head either from IDLE or at the very end of a
  // stop bit, which is what makes consecutive frames contiguous.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign tx_ready      = (r_count != LVL_W'(FIFO_DEPTH));
  assign tx_fifo_level = r_count;
  assign tx            = r_tx;
  assign tx_busy       = (r_state != S_IDLE);
  assign tx_done       = r_tx_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Level comes from its own counter; a simultaneous push and pop cancel.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; a flush only clears pointers and the
  // count, so stale contents are never observable and the array can map to RAM.
  always_ff @(posedge clk_3125) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // tx is loaded with the value of the bit being entered, so the line changes
  // on the same edge as the state and never glitches.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      // Pulse is registered one cycle early so it is high during the last
      // cycle of the stop bit.
      r_tx_done <= (r_state == S_STOP) && (r_cyc == CYC_W'(CLKS_PER_BIT - 2));
      r_cyc     <= w_bit_end ? '0 : r_cyc + CYC_W'(1);

      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cyc <= '0;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_state   <= S_START;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[7];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= ^r_shift;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[3'd6 - r_bit_idx];
            end
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift   <= r_mem[r_rd_ptr];
              r_state   <= S_START;
              r_bit_idx <= '0;
              r_tx      <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB   = 14;
  localparam int FRAME = 11 * CPB;  // 154 cycles

  logic       clk_3125;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] tx_fifo_level;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1)) dut (
    .clk_3125      (clk_3125),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_fifo_level (tx_fifo_level)
  );

  initial clk_3125 = 1'b0;
  always #5 clk_3125 = ~clk_3125;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [FRAME-1:0] obs,
                       input logic [FRAME-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of bytes the bench handed over, and the ideal
  // line waveform of a frame built straight from the frame format.
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_exp_frames = 0;

  function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
    logic [10:0]      bits;
    logic [FRAME-1:0] w;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[7-k];
    bits[9]  = ^b;
    bits[10] = 1'b1;
    for (int i = 0; i < FRAME; i++) w[i] = bits[i / CPB];
    return w;
  endfunction

  function automatic logic [FRAME-1:0] done_wave();
    logic [FRAME-1:0] w;
    w = '0;
    w[FRAME-1] = 1'b1;
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Line monitor: samples every falling edge, frames start on tx low.
  // ---------------------------------------------------------------------------
  int         cycle = 0;
  int         mon_idx = -1;
  int         done_total = 0;
  int         frame_start_q[$];
  logic       par_q[$];

  always @(posedge clk_3125) cycle <= cycle + 1;

  initial begin : monitor
    logic [FRAME-1:0] w_obs, d_obs, b_obs;
    logic [7:0]       exp_b;
    w_obs = '0; d_obs = '0; b_obs = '0;
    forever begin
      @(negedge clk_3125);
      if (rst) begin
        mon_idx = -1;
      end else begin
        if (tx_done) done_total++;
        if (mon_idx < 0 && tx == 1'b0) begin
          mon_idx = 0;
          frame_start_q.push_back(cycle);
        end
        if (mon_idx >= 0) begin
          w_obs[mon_idx] = tx;
          d_obs[mon_idx] = tx_done;
          b_obs[mon_idx] = tx_busy;
          mon_idx++;
          if (mon_idx == FRAME) begin
            mon_idx = -1;
            par_q.push_back(w_obs[9*CPB + CPB/2]);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", w_obs, '1);
            end else begin
              exp_b = exp_q.pop_front();
              check("frame_wave", w_obs, frame_wave(exp_b));
              check("frame_done", d_obs, done_wave());
              check("frame_busy", b_obs, '1);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_3125);
    while (!tx_ready && n < 2000) begin
      @(negedge clk_3125);
      n++;
    end
    if (n >= 2000) check("push_ready_timeout", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    n_exp_frames++;
    @(posedge clk_3125);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_3125);
      if (exp_q.size() == 0 && mon_idx < 0 && !tx_busy) begin
        ok = 1;
        break;
      end
    end
    check("wait_idle_timeout", ok, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int         base;
    int         done0;
    int         ok;
    logic [7:0] d;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk_3125);
    #2;
    check("rst_tx",    tx, 1'b1);
    check("rst_busy",  tx_busy, 1'b0);
    check("rst_done",  tx_done, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_level", tx_fifo_level, 3'd0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk_3125);

    // 1. single byte, latency and timing
    @(negedge clk_3125);
    tx_valid = 1'b1;
    tx_data  = 8'h41;
    exp_q.push_back(8'h41);
    n_exp_frames++;
    @(posedge clk_3125);
    #1 tx_valid = 1'b0;
    check("lat_tx_push_edge",    tx, 1'b1);
    check("lat_level_push_edge", tx_fifo_level, 3'd1);
    @(posedge clk_3125);
    #1;
    check("lat_tx_falls",   tx, 1'b0);
    check("lat_busy",       tx_busy, 1'b1);
    check("lat_level_pop",  tx_fifo_level, 3'd0);
    wait_idle(400);
    check("t1_busy_drops", tx_busy, 1'b0);
    check("t1_tx_idle",    tx, 1'b1);

    // 2. parity cases
    par_q.delete();
    push_byte(8'hA5);
    push_byte(8'h07);
    wait_idle(800);
    check("par_count", par_q.size(), 2);
    if (par_q.size() == 2) begin
      check("par_A5", par_q[0], 1'b0);
      check("par_07", par_q[1], 1'b1);
    end

    // 3. burst of 8 valid cycles from IDLE: first 5 accepted
    base  = frame_start_q.size();
    done0 = done_total;
    @(negedge clk_3125);
    for (int k = 1; k <= 8; k++) begin
      d        = 8'($urandom);
      tx_valid = 1'b1;
      tx_data  = d;
      check($sformatf("burst_ready_%0d", k), tx_ready, (k <= 5) ? 1'b1 : 1'b0);
      if (k <= 5) begin
        exp_q.push_back(d);
        n_exp_frames++;
      end
      @(negedge clk_3125);
    end
    tx_valid = 1'b0;
    check("burst_level", tx_fifo_level, 3'd4);
    wait_idle(5 * FRAME + 200);
    check("burst_frames", frame_start_q.size() - base, 5);
    check("burst_dones",  done_total - done0, 5);
    if (frame_start_q.size() - base == 5)
      for (int k = 1; k < 5; k++)
        check($sformatf("burst_gap_%0d", k),
              frame_start_q[base+k] - frame_start_q[base+k-1], FRAME);

    // 4. push coinciding with STOP-end pop at level 1
    push_byte(8'h11);
    push_byte(8'h22);
    @(negedge clk_3125);
    check("coinc_level_before", tx_fifo_level, 3'd1);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_done) begin
        ok = 1;
        break;
      end
      @(negedge clk_3125);
    end
    check("coinc_done_seen", ok, 1);
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    exp_q.push_back(8'h33);
    n_exp_frames++;
    @(posedge clk_3125);
    #1 tx_valid = 1'b0;
    check("coinc_level_after", tx_fifo_level, 3'd1);
    check("coinc_tx_start",    tx, 1'b0);
    wait_idle(3 * FRAME + 200);

    // 5. reset in the middle of a frame
    push_byte(8'hC3);
    push_byte(8'h5A);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_3125);
      if (mon_idx >= 70) begin
        ok = 1;
        break;
      end
    end
    check("abort_reach_70", ok, 1);
    @(posedge clk_3125);
    done0 = done_total;
    #3 rst = 1'b1;
    #1;
    check("abort_tx",    tx, 1'b1);
    check("abort_ready", tx_ready, 1'b1);
    check("abort_busy",  tx_busy, 1'b0);
    check("abort_level", tx_fifo_level, 3'd0);
    exp_q.delete();
    n_exp_frames -= 2;
    repeat (3) @(posedge clk_3125);
    #3 rst = 1'b0;
    repeat (FRAME) @(negedge clk_3125);
    check("abort_no_done", done_total - done0, 0);
    check("abort_no_frame", mon_idx, -1);
    push_byte(8'h3F);
    wait_idle(400);

    // 6. link characters, then random traffic with random gaps
    push_byte(8'h52);
    push_byte(8'h47);
    push_byte(8'h42);
    wait_idle(4 * FRAME + 200);
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 180)) @(negedge clk_3125);
      push_byte(8'($urandom));
    end
    wait_idle(20 * FRAME);

    check("queue_drained", exp_q.size(), 0);
    check("done_total",    done_total, n_exp_frames);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
